uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encoding for the UART transmit arbiter
package uart_pkg;

    localparam int BYTE_W          = 8;
    localparam int TIMEOUT_DEFAULT = 65535;
    localparam int TO_CNT_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_ACT  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RELEASE   = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting one past the last grant
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             valid_o
);

    logic             found;
    logic [IDX_W-1:0] pick;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offset);
        return IDX_W'((int'(base) + offset) % N_REQ);
    endfunction

    // Offsets 1..N_REQ walk the ring once; the first requesting slot wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req_i[wrap_idx(last_grant_i, k)]) begin
                found = 1'b1;
                pick  = wrap_idx(last_grant_i, k);
            end
        end
    end

    always_comb begin
        grant_o = '0;
        if (found) begin
            grant_o[pick] = 1'b1;
        end
    end

    assign grant_idx_o = pick;
    assign valid_o     = found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART Tx unit between N_REQ byte requesters
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [BYTE_W*N_REQ-1:0]   req_data_i,
    output logic [N_REQ-1:0]          ack_o,
    output logic [N_REQ-1:0]          done_o,
    output logic                      err_o,
    output logic                      tx_send_o,
    output logic [BYTE_W-1:0]         tx_data_o,
    input  logic                      tx_active_i,
    input  logic                      tx_done_i,
    output logic                      busy_o
);

    localparam int                  IDX_W       = $clog2(N_REQ);
    localparam logic [IDX_W-1:0]    LAST_RESET  = IDX_W'(N_REQ - 1);
    localparam logic [TO_CNT_W:0]   TIMEOUT_EXT = (TO_CNT_W + 1)'(TIMEOUT);
    localparam logic [TO_CNT_W-1:0] CNT_ONE     = TO_CNT_W'(1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [IDX_W-1:0]      win_q, win_d;
    logic [N_REQ-1:0]      ack_q, ack_d;
    logic [N_REQ-1:0]      done_q, done_d;
    logic                  err_q, err_d;
    logic                  tx_send_q, tx_send_d;
    logic [BYTE_W-1:0]     tx_data_q, tx_data_d;
    logic [TO_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  tx_done_prev_q;

    logic [N_REQ-1:0]      arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_valid;
    logic                  timeout_hit;
    logic                  tx_done_rise;
    logic [N_REQ-1:0]      win_onehot;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i        (req_i),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .grant_idx_o  (arb_idx),
        .valid_o      (arb_valid)
    );

    // Fires on the cycle whose increment would bring the counter to TIMEOUT.
    assign timeout_hit  = ({1'b0, cnt_q} + {{TO_CNT_W{1'b0}}, 1'b1}) >= TIMEOUT_EXT;
    assign tx_done_rise = tx_done_i & ~tx_done_prev_q;
    assign win_onehot   = N_REQ'(1) << win_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= LAST_RESET;
            win_q          <= '0;
            ack_q          <= '0;
            done_q         <= '0;
            err_q          <= 1'b0;
            tx_send_q      <= 1'b0;
            tx_data_q      <= '0;
            cnt_q          <= '0;
            tx_done_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            win_q          <= win_d;
            ack_q          <= ack_d;
            done_q         <= done_d;
            err_q          <= err_d;
            tx_send_q      <= tx_send_d;
            tx_data_q      <= tx_data_d;
            cnt_q          <= cnt_d;
            tx_done_prev_q <= tx_done_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT_ACT;
            end
            ST_WAIT_ACT: begin
                if (tx_active_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done_rise || timeout_hit) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ack_d        = '0;
        done_d       = '0;
        err_d        = 1'b0;
        tx_send_d    = 1'b0;
        tx_data_d    = tx_data_q;
        win_d        = win_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    ack_d     = arb_grant;
                    win_d     = arb_idx;
                    tx_data_d = req_data_i[BYTE_W*int'(arb_idx) +: BYTE_W];
                end
            end
            ST_LOAD: begin
                tx_send_d = 1'b1;
            end
            ST_WAIT_ACT: begin
                if (!tx_active_i && timeout_hit) begin
                    done_d = win_onehot;
                    err_d  = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done_rise) begin
                    done_d = win_onehot;
                end else if (timeout_hit) begin
                    done_d = win_onehot;
                    err_d  = 1'b1;
                end
            end
            ST_RELEASE: begin
                last_grant_d = win_q;
            end
            default: begin
                last_grant_d = last_grant_q;
            end
        endcase

        // Counter restarts on every state change and saturates while waiting.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == ST_WAIT_ACT) || (state_q == ST_WAIT_DONE)) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
        end
    end

    assign ack_o     = ack_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign tx_send_o = tx_send_q;
    assign tx_data_o = tx_data_q;
    assign busy_o    = (state_q != ST_IDLE);

endmodule
